// File: rtl/scene_state_buffer.sv
// scene_state_buffer
//   Double-buffered scene state: decoded instructions edit a shadow set
//   (one camera plus NUM_LIGHTS lights); an opFrame copies the whole shadow
//   set into the active set once the renderer is not busy.
//
//   Optional feature: define SCENE_STATE_ERR_EN to make err a sticky flag
//   that is set by dropped writes. Without it, err is tied to 0.
//
// Ports
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   inst_valid/ready   instruction handshake (accepted when both high)
//   inst_type          InstructionType: 1 opCameraSet, 2 opLightSet, 3 opFrame,
//                      all other codes (0 opNop, 4-15) are consumed with no effect
//   inst_lindex        light slot for opLightSet
//   inst_prop          CameraProperty or LightProperty code
//   inst_data          property value (float16 at the default width)
//   render_busy        consumer is reading the active set; commit has to wait
//   rd_lidx            light slot to read back (1-cycle latency)
//   rd_light           Light packed: [1:0] lType, then lpXLocation..lpIntensity
//                      (codes 1..8), DATA_WIDTH bits each, LSB first
//   rd_camera          Camera packed: cpXLocation..cpFovVer (codes 1..13),
//                      DATA_WIDTH bits each, LSB first
//   frame_commit       one-cycle pulse while the active set is being loaded
//   err                sticky illegal-write flag
module scene_state_buffer #(
   parameter int unsigned NUM_LIGHTS = 2,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                                             clk_in,
   input  logic                                             rst_n_in,
   input  logic                                             inst_valid,
   output logic                                             inst_ready,
   input  logic [3:0]                                       inst_type,
   input  logic [5:0]                                       inst_lindex,
   input  logic [4:0]                                       inst_prop,
   input  logic [DATA_WIDTH-1:0]                            inst_data,
   input  logic                                             render_busy,
   input  logic [(NUM_LIGHTS > 1 ? $clog2(NUM_LIGHTS) : 1)-1:0] rd_lidx,
   output logic [8*DATA_WIDTH+1:0]                          rd_light,
   output logic [13*DATA_WIDTH-1:0]                         rd_camera,
   output logic                                             frame_commit,
   output logic                                             err
);

   localparam int unsigned CamW   = 13 * DATA_WIDTH;
   localparam int unsigned LightW = 8 * DATA_WIDTH + 2;
   localparam int unsigned LIdxW  = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;

   localparam logic [3:0] opCameraSet = 4'd1;
   localparam logic [3:0] opLightSet  = 4'd2;
   localparam logic [3:0] opFrame     = 4'd3;

   localparam logic [4:0] cpXLocation = 5'd1;
   localparam logic [4:0] cpFovVer    = 5'd13;
   localparam logic [4:0] lpType      = 5'd0;
   localparam logic [4:0] lpIntensity = 5'd8;

   typedef enum logic [1:0] {StIdle, StWaitCommit, StCommit} sceneState_t;

   sceneState_t stateQ, stateD;

   logic accept;
   logic camPropOk, lightPropOk, lightInRange;
   logic camWrite, lightWrite, doCommit;

   logic [CamW-1:0]   shCam, actCam;
   logic [LightW-1:0] shLight  [NUM_LIGHTS];
   logic [LightW-1:0] actLight [NUM_LIGHTS];

   assign accept       = inst_valid & inst_ready;
   assign camPropOk    = (inst_prop >= cpXLocation) && (inst_prop <= cpFovVer);
   assign lightPropOk  = (inst_prop <= lpIntensity);
   assign lightInRange = (32'(inst_lindex) < NUM_LIGHTS);
   assign camWrite     = accept && (inst_type == opCameraSet) && camPropOk;
   assign lightWrite   = accept && (inst_type == opLightSet) && lightInRange && lightPropOk;
   assign doCommit     = (stateQ == StCommit);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) stateQ <= StIdle;
      else           stateQ <= stateD;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle: begin
            if (accept && (inst_type == opFrame)) begin
               stateD = render_busy ? StWaitCommit : StCommit;
            end
         end
         StWaitCommit: if (!render_busy) stateD = StCommit;
         StCommit:     stateD = StIdle;
         default:      stateD = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      inst_ready   = (stateQ == StIdle);
      frame_commit = (stateQ == StCommit);
   end

   // ---------------- shadow set ----------------
   // Constant part-selects per property code keep the write decode lint-clean.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         shCam <= '0;
         for (int i = 0; i < NUM_LIGHTS; i++) shLight[i] <= '0;
      end else begin
         if (camWrite) begin
            for (int p = 1; p <= 13; p++) begin
               if (inst_prop == 5'(p)) shCam[(p-1)*DATA_WIDTH +: DATA_WIDTH] <= inst_data;
            end
         end
         if (lightWrite) begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
               if (inst_lindex == 6'(i)) begin
                  if (inst_prop == lpType) shLight[i][1:0] <= inst_data[1:0];
                  for (int p = 1; p <= 8; p++) begin
                     if (inst_prop == 5'(p)) begin
                        shLight[i][2+(p-1)*DATA_WIDTH +: DATA_WIDTH] <= inst_data;
                     end
                  end
               end
            end
         end
      end
   end

   // ---------------- active set and registered readback ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         actCam    <= '0;
         rd_camera <= '0;
         rd_light  <= '0;
         for (int i = 0; i < NUM_LIGHTS; i++) actLight[i] <= '0;
      end else begin
         if (doCommit) begin
            actCam <= shCam;
            for (int i = 0; i < NUM_LIGHTS; i++) actLight[i] <= shLight[i];
         end
         rd_camera <= actCam;
         // Out-of-range slot matches nothing and reads back as zero.
         rd_light <= '0;
         for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (rd_lidx == LIdxW'(i)) rd_light <= actLight[i];
         end
      end
   end

   // ---------------- error flag ----------------
`ifdef SCENE_STATE_ERR_EN
   logic dropWrite;
   logic errQ;

   assign dropWrite = accept &&
                      (((inst_type == opCameraSet) && !camPropOk) ||
                       ((inst_type == opLightSet) && !(lightInRange && lightPropOk)));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)      errQ <= 1'b0;
      else if (dropWrite) errQ <= 1'b1;
   end

   assign err = errQ;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_scene_state_buffer.sv
// Testbench for scene_state_buffer (default parameters NUM_LIGHTS=2, DATA_WIDTH=16).
// Reference model keeps the scene as plain property arrays indexed by property
// code and only packs them into the output layout at comparison time.
module tb_scene_state_buffer;

   localparam int N  = 2;
   localparam int DW = 16;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_CAM   = 4'd1;
   localparam logic [3:0] OP_LIGHT = 4'd2;
   localparam logic [3:0] OP_FRAME = 4'd3;

   logic             clk_in = 1'b0;
   logic             rst_n_in;
   logic             inst_valid;
   logic             inst_ready;
   logic [3:0]       inst_type;
   logic [5:0]       inst_lindex;
   logic [4:0]       inst_prop;
   logic [DW-1:0]    inst_data;
   logic             render_busy;
   logic [0:0]       rd_lidx;
   logic [8*DW+1:0]  rd_light;
   logic [13*DW-1:0] rd_camera;
   logic             frame_commit;
   logic             err;

   scene_state_buffer #(.NUM_LIGHTS(N), .DATA_WIDTH(DW)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst_type    (inst_type),
      .inst_lindex  (inst_lindex),
      .inst_prop    (inst_prop),
      .inst_data    (inst_data),
      .render_busy  (render_busy),
      .rd_lidx      (rd_lidx),
      .rd_light     (rd_light),
      .rd_camera    (rd_camera),
      .frame_commit (frame_commit),
      .err          (err)
   );

   always #5 clk_in = ~clk_in;

   int nVec = 0;
   int nErr = 0;

   // Model: camera properties 1..13, light properties 0..8 (0 = lType).
   logic [15:0] shCamM  [1:13];
   logic [15:0] actCamM [1:13];
   logic [15:0] shLightM  [N][0:8];
   logic [15:0] actLightM [N][0:8];
   logic        errM;

   function automatic logic [207:0] packCam();
      logic [207:0] v = '0;
      for (int p = 1; p <= 13; p++) v[(p-1)*16 +: 16] = actCamM[p];
      return v;
   endfunction

   function automatic logic [129:0] packLight(input int idx);
      logic [129:0] v = '0;
      if (idx < N) begin
         v[1:0] = actLightM[idx][0][1:0];
         for (int p = 1; p <= 8; p++) v[2+(p-1)*16 +: 16] = actLightM[idx][p];
      end
      return v;
   endfunction

   function automatic logic expErr();
`ifdef SCENE_STATE_ERR_EN
      return errM;
`else
      return 1'b0;
`endif
   endfunction

   task automatic clearModel();
      for (int p = 1; p <= 13; p++) begin shCamM[p] = '0; actCamM[p] = '0; end
      for (int i = 0; i < N; i++)
         for (int p = 0; p <= 8; p++) begin shLightM[i][p] = '0; actLightM[i][p] = '0; end
      errM = 1'b0;
   endtask

   task automatic commitModel();
      for (int p = 1; p <= 13; p++) actCamM[p] = shCamM[p];
      for (int i = 0; i < N; i++)
         for (int p = 0; p <= 8; p++) actLightM[i][p] = shLightM[i][p];
   endtask

   task automatic modelAccept(input logic [3:0] t, input logic [5:0] l, input logic [4:0] p,
                              input logic [15:0] d);
      if (t == OP_CAM) begin
         if (p >= 1 && p <= 13) shCamM[p] = d;
         else errM = 1'b1;
      end else if (t == OP_LIGHT) begin
         if (int'(l) < N && p <= 8) shLightM[l][p] = (p == 0) ? (d & 16'h0003) : d;
         else errM = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic sendInst(input logic [3:0] t, input logic [5:0] l, input logic [4:0] p,
                           input logic [15:0] d);
      int waitCnt;
      waitCnt     = 0;
      inst_type   = t;
      inst_lindex = l;
      inst_prop   = p;
      inst_data   = d;
      inst_valid  = 1'b1;
      while (!inst_ready && waitCnt < 20) begin
         @(negedge clk_in);
         waitCnt++;
      end
      if (!inst_ready) begin
         nVec++;
         nErr++;
         $error("FAIL ready_timeout: observed inst_ready=0 expected 1 within 20 cycles");
         inst_valid = 1'b0;
         return;
      end
      @(posedge clk_in);
      modelAccept(t, l, p, d);
      @(negedge clk_in);
      inst_valid = 1'b0;
   endtask

   task automatic doFrame(input int busyCycles);
      render_busy = (busyCycles > 0);
      sendInst(OP_FRAME, 6'd0, 5'd0, 16'h0);
      for (int k = 0; k < busyCycles; k++) begin
         check("wait_no_commit", 256'(frame_commit), 256'(0));
         check("wait_not_ready", 256'(inst_ready), 256'(0));
         @(negedge clk_in);
      end
      if (busyCycles > 0) begin
         render_busy = 1'b0;
         @(negedge clk_in);
      end
      check("commit_pulse", 256'(frame_commit), 256'(1));
      check("commit_not_ready", 256'(inst_ready), 256'(0));
      commitModel();
      @(negedge clk_in);
      check("commit_pulse_end", 256'(frame_commit), 256'(0));
      check("ready_after_commit", 256'(inst_ready), 256'(1));
   endtask

   task automatic readCheck(input int idx);
      rd_lidx = 1'(idx);
      @(negedge clk_in);
      check("rd_camera", 256'(rd_camera), 256'(packCam()));
      check("rd_light", 256'(rd_light), 256'(packLight(idx)));
      check("err", 256'(err), 256'(expErr()));
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_cam"}, 256'(rd_camera), 256'(0));
      check({tag, "_light"}, 256'(rd_light), 256'(0));
      check({tag, "_fc"}, 256'(frame_commit), 256'(0));
      check({tag, "_err"}, 256'(err), 256'(0));
      check({tag, "_ready"}, 256'(inst_ready), 256'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [3:0] t;

      rst_n_in = 1'b0; inst_valid = 1'b0; inst_type = '0; inst_lindex = '0;
      inst_prop = '0; inst_data = '0; render_busy = 1'b0; rd_lidx = '0;
      clearModel();
      repeat (2) @(negedge clk_in);
      checkAllZero("reset");
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("ready_after_reset", 256'(inst_ready), 256'(1));

      // Camera xloc write then immediate commit
      sendInst(OP_CAM, 6'd0, 5'd1, 16'h3C00);
      doFrame(0);
      readCheck(0);
      check("xloc", 256'(rd_camera[15:0]), 256'(16'h3C00));

      // Shadow-only edit must not reach the active set
      sendInst(OP_LIGHT, 6'd1, 5'd7, 16'hF800);
      readCheck(1);
      check("col_uncommitted", 256'(rd_light[2+6*16 +: 16]), 256'(16'h0000));

      // Long busy wait; the pending colour commits afterwards
      doFrame(10);
      readCheck(1);
      check("col_committed", 256'(rd_light[2+6*16 +: 16]), 256'(16'hF800));

      // Out-of-range light slot and illegal property codes
      sendInst(OP_LIGHT, 6'd5, 5'd1, 16'h1234);
      sendInst(OP_CAM, 6'd0, 5'd0, 16'h5555);
      sendInst(OP_CAM, 6'd0, 5'd20, 16'h6666);
      sendInst(OP_LIGHT, 6'd0, 5'd12, 16'h7777);
      doFrame(0);
      readCheck(0);
      readCheck(1);

      // Back-to-back camera writes, one commit
      sendInst(OP_CAM, 6'd0, 5'd2, 16'h1111);
      sendInst(OP_CAM, 6'd0, 5'd3, 16'h2222);
      sendInst(OP_CAM, 6'd0, 5'd13, 16'h3333);
      doFrame(0);
      readCheck(0);

      // lType=2 on light 0, then reset in the middle of WAIT_COMMIT
      sendInst(OP_LIGHT, 6'd0, 5'd0, 16'hFFFE);
      doFrame(0);
      readCheck(0);
      check("ltype", 256'(rd_light[1:0]), 256'(2));
      sendInst(OP_CAM, 6'd0, 5'd4, 16'hABCD);
      render_busy = 1'b1;
      sendInst(OP_FRAME, 6'd0, 5'd0, 16'h0);
      @(negedge clk_in);
      #2 rst_n_in = 1'b0;
      #1 checkAllZero("mid_wait_reset");
      clearModel();
      @(negedge clk_in);
      rst_n_in = 1'b1;
      render_busy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_in);
         check("no_commit_after_reset", 256'(frame_commit), 256'(0));
      end
      readCheck(0);

      // Randomised traffic; render_busy wiggles while idle
      repeat (80) begin
         r = int'($urandom_range(0, 9));
         render_busy = 1'($urandom_range(0, 1));
         if (r == 0) begin
            doFrame(int'($urandom_range(0, 3)));
            render_busy = 1'($urandom_range(0, 1));
            readCheck(0);
            readCheck(1);
         end else begin
            if (r < 5)      t = OP_CAM;
            else if (r < 9) t = OP_LIGHT;
            else            t = ($urandom_range(0, 1) == 0) ? OP_NOP : 4'($urandom_range(4, 15));
            sendInst(t, 6'($urandom_range(0, 3)), 5'($urandom_range(0, 15)), 16'($urandom));
         end
      end
      doFrame(0);
      readCheck(0);
      readCheck(1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/scene_state_buffer.md
SCENE_STATE_BUFFER -- requirements
Module: scene_state_buffer

Interface
REQ-001 SHALL have parameter NUM_LIGHTS, default 2, number of light slots (1..64).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of one property word (float16).
REQ-003 SHALL have ports clk_in input 1, system clock; rst_n_in input 1, reset.
REQ-004 SHALL have inst_valid input 1, decoded instruction present; inst_ready output 1, instruction accepted when both high.
REQ-005 SHALL have inst_type input 4 (InstructionType), inst_lindex input 6, inst_prop input 5, inst_data input DATA_WIDTH.
REQ-006 SHALL have render_busy input 1, consumer is reading the active set and commit must wait.
REQ-007 SHALL have rd_lidx input clog2(NUM_LIGHTS), rd_light output LIGHT_WIDTH (Light packed), rd_camera output CAMERA_WIDTH (Camera packed).
REQ-008 SHALL have frame_commit output 1, one-cycle pulse when the shadow set is copied to the active set.
REQ-009 SHALL have err output 1, sticky illegal-write flag (see Configuration).
REQ-010 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-011 SHALL hold a shadow set (1 Camera + NUM_LIGHTS Light) and an active set of identical shape.
REQ-012 SHALL implement states IDLE, WAIT_COMMIT, COMMIT.
REQ-013 In IDLE, inst_ready SHALL be 1; in WAIT_COMMIT and COMMIT it SHALL be 0.
REQ-014 Accepted opCameraSet SHALL write inst_data into shadow camera field by CameraProperty (cpXLocation..cpFovVer); cpNull and codes 14-31 SHALL write nothing.
REQ-015 Accepted opLightSet with inst_lindex < NUM_LIGHTS SHALL write shadow light[inst_lindex] by LightProperty; lpType SHALL take inst_data[1:0]; codes 9-31 write nothing.
REQ-016 opLightSet with inst_lindex >= NUM_LIGHTS SHALL write nothing.
REQ-017 Any other accepted inst_type except opFrame SHALL be consumed with no state change.
REQ-018 Shadow writes SHALL be visible in shadow registers on the cycle after acceptance; active set SHALL NOT change.
REQ-019 Accepted opFrame with render_busy=0 SHALL go IDLE->COMMIT; with render_busy=1 SHALL go IDLE->WAIT_COMMIT.
REQ-020 WAIT_COMMIT SHALL move to COMMIT on the first cycle render_busy=0.
REQ-021 COMMIT SHALL last exactly one cycle: active<=shadow in full, frame_commit=1, then return to IDLE.
REQ-022 opFrame accept to frame_commit SHALL be exactly 1 cycle when render_busy=0; next instruction acceptable 2 cycles after opFrame accept.
REQ-023 rd_camera and rd_light SHALL be registered, 1-cycle latency from rd_lidx, sourced from the active set only; rd_lidx >= NUM_LIGHTS SHALL return all zeros.
REQ-024 Shadow SHALL retain contents after commit (incremental edits across frames).
REQ-025 render_busy toggling in IDLE or COMMIT SHALL have no effect.

Reset
REQ-026 On rst_n_in low, SHALL asynchronously clear shadow and active sets to 0 (lType=ltOff), state=IDLE, rd_camera=0, rd_light=0, frame_commit=0, err=0; inst_ready SHALL be 1 after release.
REQ-027 Reset during WAIT_COMMIT or COMMIT SHALL abort the commit; no frame_commit pulse after release.

Configuration
REQ-028 Macro SCENE_STATE_ERR_EN: when defined, err SHALL set the cycle after an accepted write dropped under REQ-014/015/016 and stay 1 until reset.
REQ-029 Without SCENE_STATE_ERR_EN, err SHALL be constant 0 and drop logic SHALL be otherwise identical.

Verification
REQ-030 Reset, write cpXLocation=16'h3C00, opFrame with render_busy=0 -> frame_commit 1 cycle later; rd_camera.xloc=16'h3C00 next read.
REQ-031 Write lpColor=16'hF800 to light 1, no opFrame -> rd_light(1).col stays 16'h0000.
REQ-032 render_busy=1, opFrame -> inst_ready=0, no frame_commit for 10 cycles; drop render_busy -> frame_commit next cycle, then inst_ready=1.
REQ-033 opLightSet lindex=5 (NUM_LIGHTS=2) -> no state change; err=1 with SCENE_STATE_ERR_EN, err=0 without.
REQ-034 Commit lType=2 on light 0, then rst_n_in low mid-WAIT_COMMIT -> all outputs 0, no frame_commit after release.
REQ-035 Back-to-back: 3 camera writes at full rate then opFrame -> all three fields committed in one frame_commit pulse.
